prefetch_queue: RTL and testbench

//  Parametrised instruction prefetch unit with an integral byte queue. It fetches 16-bit words

---
 rtl/prefetch_queue.sv | 168 ++++++++++++++++
 tb/tb_prefetch_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch unit: fetches 16-bit words from CS:IP
// and hands them to decode as a byte stream with 2-byte lookahead.
module prefetch_queue #(
  parameter int          DEPTH    = 6,
  parameter logic [15:0] RESET_CS = 16'hFFFF,
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                new_cs,
  input  logic [15:0]                new_ip,
  input  logic                       load_new_ip,
  output logic                       mem_access,
  input  logic                       mem_ack,
  output logic [19:1]                mem_address,
  input  logic [15:0]                mem_data,
  input  logic                       rd_en,
  output logic [7:0]                 rd_data,
  output logic [7:0]                 rd_data_next,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DISCARD
  } state_t;

  state_t        r_state;
  logic [7:0]    r_q [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [LW-1:0] r_level;
  logic          r_empty;
  logic [15:0]   r_cs;
  logic [15:0]   r_ip;
  logic [19:1]   r_addr;
  logic          r_access;

  logic          w_pop;
  logic          w_ack_wr;
  logic [1:0]    w_wr_cnt;
  logic [LW-1:0] w_wr_n;
  logic [LW-1:0] w_level_pop;
  logic [LW-1:0] w_level_nxt;
  logic          w_start;
  logic [19:1]   w_word;
  logic [PW-1:0] w_rd_ptr1;
  logic [PW-1:0] w_wr_ptr1;

  function automatic logic [PW-1:0] ptr_add(
    input logic [PW-1:0] p,
    input logic [1:0]    n
  );
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= (PW+1)'(DEPTH))
      s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  // cs*16 has a zero low nibble, so the word
  // address needs no carry from IP bit 0
  assign w_word = {r_cs, 3'b000}
                + {4'b0000, r_ip[15:1]};

  assign w_pop    = rd_en & ~r_empty;
  assign w_ack_wr = (r_state == S_FETCH) & mem_ack
                  & ~load_new_ip & ~reset;
  assign w_wr_cnt = r_ip[0] ? 2'd1 : 2'd2;
  assign w_wr_n   = w_ack_wr ? LW'(w_wr_cnt) : '0;

  assign w_level_pop = r_level - LW'(w_pop);
  assign w_level_nxt = w_level_pop + w_wr_n;
  assign w_start     = (w_level_pop <= LW'(DEPTH - 2));

  assign w_rd_ptr1 = ptr_add(r_rd_ptr, 2'd1);
  assign w_wr_ptr1 = ptr_add(r_wr_ptr, 2'd1);

  always_ff @(posedge clk) begin
    if (w_ack_wr) begin
      if (r_ip[0]) begin
        r_q[r_wr_ptr]  <= mem_data[15:8];
      end else begin
        r_q[r_wr_ptr]  <= mem_data[7:0];
        r_q[w_wr_ptr1] <= mem_data[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_cs     <= RESET_CS;
      r_ip     <= RESET_IP;
    end else if (load_new_ip) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_cs     <= new_cs;
      r_ip     <= new_ip;
    end else begin
      if (w_pop)
        r_rd_ptr <= w_rd_ptr1;
      if (w_ack_wr) begin
        r_wr_ptr <= ptr_add(r_wr_ptr, w_wr_cnt);
        r_ip     <= r_ip + 16'(w_wr_cnt);
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
    end
  end

  // Address is latched on entry to FETCH so it
  // stays put while a flush retargets CS:IP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_access <= 1'b0;
      r_addr   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!load_new_ip && w_start) begin
            r_state  <= S_FETCH;
            r_access <= 1'b1;
            r_addr   <= w_word;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            r_state  <= S_IDLE;
            r_access <= 1'b0;
          end else if (load_new_ip) begin
            r_state  <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (mem_ack) begin
            r_state  <= S_IDLE;
            r_access <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_access <= 1'b0;
        end
      endcase
    end
  end

  assign mem_access   = r_access;
  assign mem_address  = r_addr;
  assign empty        = r_empty;
  assign level        = r_level;
  assign rd_data      = r_empty ? 8'h00 : r_q[r_rd_ptr];
  assign rd_data_next = (r_level >= LW'(2))
                      ? r_q[w_rd_ptr1] : 8'h00;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: reset, fetch
// addressing, odd IP, flush, segment wrap, fill limit.
module tb_prefetch_queue;

  logic        clk;
  logic        reset;
  logic [15:0] new_cs;
  logic [15:0] new_ip;
  logic        load_new_ip;
  logic        mem_access;
  logic        mem_ack;
  logic [19:1] mem_address;
  logic [15:0] mem_data;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic [7:0]  rd_data_next;
  logic        empty;
  logic [2:0]  level;

  int n_total = 0;
  int n_bad   = 0;

  prefetch_queue #(
    .DEPTH(6),
    .RESET_CS(16'hFFFF),
    .RESET_IP(16'h0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .new_cs(new_cs),
    .new_ip(new_ip),
    .load_new_ip(load_new_ip),
    .mem_access(mem_access),
    .mem_ack(mem_ack),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_data_next(rd_data_next),
    .empty(empty),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    new_cs      = '0;
    new_ip      = '0;
    load_new_ip = 1'b0;
    mem_ack     = 1'b0;
    mem_data    = '0;
    rd_en       = 1'b0;
    step();
    step();
    check("rst_access", 32'(mem_access), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    check("rst_rdn", 32'(rd_data_next), 32'd0);

    // first fetch from FFFF:0000
    reset = 1'b0;
    step();
    check("t1_access", 32'(mem_access), 32'd1);
    check("t1_addr", 32'(mem_address), 32'h7FFF8);
    step();
    check("t1_hold", 32'(mem_address), 32'h7FFF8);
    mem_ack  = 1'b1;
    mem_data = 16'hEAF0;
    step();
    mem_ack = 1'b0;
    check("t1_rd", 32'(rd_data), 32'hF0);
    check("t1_rdn", 32'(rd_data_next), 32'hEA);
    check("t1_level", 32'(level), 32'd2);
    check("t1_gap", 32'(mem_access), 32'd0);
    step();
    check("t1_next_acc", 32'(mem_access), 32'd1);
    check("t1_next_addr", 32'(mem_address), 32'h7FFF9);

    // flush with coincident ack, then odd IP
    load_new_ip = 1'b1;
    new_cs      = 16'h0000;
    new_ip      = 16'h0101;
    mem_ack     = 1'b1;
    mem_data    = 16'h7777;
    step();
    load_new_ip = 1'b0;
    mem_ack     = 1'b0;
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_level0", 32'(level), 32'd0);
    check("t2_idle", 32'(mem_access), 32'd0);
    step();
    check("t2_addr", 32'(mem_address), 32'h00080);
    mem_ack  = 1'b1;
    mem_data = 16'hBBAA;
    step();
    mem_ack = 1'b0;
    check("t2_level1", 32'(level), 32'd1);
    check("t2_rd", 32'(rd_data), 32'hBB);
    check("t2_rdn", 32'(rd_data_next), 32'h00);
    step();
    check("t2_next_addr", 32'(mem_address), 32'h00081);

    // pop coincident with ack at level 1
    rd_en    = 1'b1;
    mem_ack  = 1'b1;
    mem_data = 16'h2211;
    step();
    mem_ack = 1'b0;
    check("t6_level", 32'(level), 32'd2);
    check("t6_rd", 32'(rd_data), 32'h11);
    check("t6_rdn", 32'(rd_data_next), 32'h22);
    step();
    check("t6_pop_lvl", 32'(level), 32'd1);
    check("t6_pop_rd", 32'(rd_data), 32'h22);
    step();
    check("t6_empty", 32'(empty), 32'd1);
    step();
    rd_en = 1'b0;
    check("t6_underflow", 32'(level), 32'd0);
    check("t6_empty2", 32'(empty), 32'd1);
    check("t6_addr", 32'(mem_address), 32'h00082);

    // flush while access outstanding
    load_new_ip = 1'b1;
    new_cs      = 16'h1000;
    new_ip      = 16'hFFFE;
    step();
    load_new_ip = 1'b0;
    check("t4_access", 32'(mem_access), 32'd1);
    check("t4_addr", 32'(mem_address), 32'h00082);
    check("t4_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_held", 32'(mem_access), 32'd1);
    end
    mem_ack  = 1'b1;
    mem_data = 16'h9999;
    step();
    mem_ack = 1'b0;
    check("t4_drop_empty", 32'(empty), 32'd1);
    check("t4_drop_level", 32'(level), 32'd0);
    check("t4_drop_acc", 32'(mem_access), 32'd0);

    // segment wrap at IP=FFFE
    step();
    check("t5_addr0", 32'(mem_address), 32'h0FFFF);
    mem_ack  = 1'b1;
    mem_data = 16'h4433;
    step();
    mem_ack = 1'b0;
    check("t5_level", 32'(level), 32'd2);
    check("t5_rd", 32'(rd_data), 32'h33);
    step();
    check("t5_addr1", 32'(mem_address), 32'h08000);

    // fill to DEPTH with ack held high
    mem_ack  = 1'b1;
    mem_data = 16'h6655;
    step();
    step();
    step();
    check("t3_full", 32'(level), 32'd6);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_cap", 32'(level), 32'd6);
      check("t3_stop", 32'(mem_access), 32'd0);
    end
    mem_ack = 1'b0;
    rd_en   = 1'b1;
    step();
    check("t3_pop1", 32'(mem_access), 32'd0);
    step();
    rd_en = 1'b0;
    check("t3_level4", 32'(level), 32'd4);
    check("t3_resume", 32'(mem_access), 32'd1);
    check("t3_addr", 32'(mem_address), 32'h08002);
    check("t3_rd", 32'(rd_data), 32'h55);
    check("t3_rdn", 32'(rd_data_next), 32'h66);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
